// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator core.
//   - key-code constants delivered by the keypad scanner
//   - FSM state enum and pending-operator enum
//   - key_to_op(): maps an operator key code to its op_t (OP_NONE otherwise)
package calc_pkg;

  localparam logic [4:0] KEY_SQUARE = 5'b00001;
  localparam logic [4:0] KEY_CE     = 5'b00010;
  localparam logic [4:0] KEY_EQUALS = 5'b00100;
  localparam logic [4:0] KEY_ADD    = 5'b01001;
  localparam logic [4:0] KEY_MUL    = 5'b01010;
  localparam logic [4:0] KEY_SUB    = 5'b01011;
  localparam logic [4:0] KEY_AC     = 5'b01100;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_MUL_RUN = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  function automatic op_t key_to_op(input logic [4:0] code);
    op_t op_v;
    case (code)
      KEY_ADD: op_v = OP_ADD;
      KEY_SUB: op_v = OP_SUB;
      KEY_MUL: op_v = OP_MUL;
      default: op_v = OP_NONE;
    endcase
    return op_v;
  endfunction

endpackage

// File: rtl/calc_seq_mul.sv
// calc_seq_mul: radix-2 shift-add multiplier, W x W -> 2W.
//   clock, reset : core clock, async active-low reset
//   start        : load a/b and begin (ignored while busy)
//   a, b         : operands
//   busy         : high for exactly W cycles, starting at the edge after start
//   done         : high during the final busy cycle; p is already final then,
//                  so the consumer can latch p on the same edge busy falls
//   p            : product
// Bit 0 of b is folded into the load, the remaining W-1 bits take one cycle
// each, and one trailing cycle presents the result with done asserted.
module calc_seq_mul #(
  parameter int W = 20
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [2*W-1:0] mcand_r;
  logic [2*W-1:0] prod_r;
  logic [W-1:0]   mplier_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;

  assign busy = busy_r;
  assign done = done_r;
  assign p    = prod_r;

  // Load, iterate one multiplier bit per cycle, then flag completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_r  <= {(2*W){1'b0}};
      prod_r   <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start && !busy_r) begin
      prod_r   <= b[0] ? {{W{1'b0}}, a} : {(2*W){1'b0}};
      mcand_r  <= {{(W-1){1'b0}}, a, 1'b0};
      mplier_r <= b >> 1;
      cnt_r    <= CNT_LOAD;
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r != CNT_ZERO) begin
        if (mplier_r[0]) begin
          prod_r <= prod_r + mcand_r;
        end else begin
          prod_r <= prod_r;
        end
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r - CNT_ONE;
        done_r   <= (cnt_r == CNT_ONE);
      end else begin
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// calc_core_param: keypad-driven hex calculator core, DIGITS hex digits wide.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   newkey   : key-valid level; accepted on its rising edge when not busy
//   keycode  : key code (see calc_pkg)
//   value    : displayed number (W = 4*DIGITS bits), registered
//   overflow : sticky overflow, cleared by reset / AC
//   busy     : multiplier running, keys dropped
// DIGITS must be at least 2.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  newkey,
  input  logic [4:0]            keycode,
  output logic [4*DIGITS-1:0]   value,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [NW-1:0] N_MAX  = NW'(DIGITS);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);

  state_t         state_r;
  state_t         mul_dest_r;
  op_t            op_r;
  op_t            mul_next_op_r;
  op_t            key_op_s;
  logic           newkey_r;
  logic           overflow_r;
  logic [W-1:0]   acc_r;
  logic [W-1:0]   entry_r;
  logic [W-1:0]   value_r;
  logic [NW-1:0]  n_r;

  logic           accept_s;
  logic           srst_s;
  logic [W:0]     sum_s;
  logic [W:0]     diff_s;
  logic [W-1:0]   alu_res_s;
  logic           alu_ovf_s;
  logic [W-1:0]   entry_shift_s;
  logic [W-1:0]   entry_first_s;
  logic           mul_start_s;
  logic [W-1:0]   mul_a_s;
  logic [W-1:0]   mul_b_s;
  logic           mul_busy_s;
  logic           mul_done_s;
  logic [2*W-1:0] mul_p_s;

  assign value    = value_r;
  assign overflow = overflow_r;
  assign busy     = mul_busy_s;

  // Rising edge of newkey while idle; AC (or CE on a result) clears everything.
  always_comb begin
    accept_s      = newkey && !newkey_r && !mul_busy_s;
    srst_s        = accept_s && ((keycode == KEY_AC) ||
                                 ((keycode == KEY_CE) && (state_r == ST_RESULT)));
    key_op_s      = key_to_op(keycode);
    entry_shift_s = {entry_r[W-5:0], keycode[3:0]};
    entry_first_s = {{(W-4){1'b0}}, keycode[3:0]};
  end

  // Add/sub datapath for the pending operator; carry/borrow is bit W.
  always_comb begin
    sum_s  = {1'b0, acc_r} + {1'b0, entry_r};
    diff_s = {1'b0, acc_r} - {1'b0, entry_r};
    case (op_r)
      OP_ADD: begin
        alu_res_s = sum_s[W-1:0];
        alu_ovf_s = sum_s[W];
      end
      OP_SUB: begin
        alu_res_s = diff_s[W-1:0];
        alu_ovf_s = diff_s[W];
      end
      default: begin
        alu_res_s = entry_r;
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Launch the multiplier for square, or for a pending multiply being evaluated.
  always_comb begin
    mul_start_s = 1'b0;
    mul_a_s     = acc_r;
    mul_b_s     = entry_r;
    if (accept_s && (keycode == KEY_SQUARE)) begin
      mul_start_s = 1'b1;
      mul_a_s     = value_r;
      mul_b_s     = value_r;
    end else if (accept_s && (state_r == ST_ENTER_B) && (op_r == OP_MUL) &&
                 ((keycode == KEY_EQUALS) || (key_op_s != OP_NONE))) begin
      mul_start_s = 1'b1;
    end else begin
      mul_start_s = 1'b0;
    end
  end

  calc_seq_mul #(.W(W)) u_mul (
    .clock (clock),
    .reset (reset),
    .start (mul_start_s),
    .a     (mul_a_s),
    .b     (mul_b_s),
    .busy  (mul_busy_s),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );

  // Calculator FSM and registered display/overflow outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      newkey_r      <= 1'b0;
      state_r       <= ST_ENTER_A;
      mul_dest_r    <= ST_RESULT;
      op_r          <= OP_NONE;
      mul_next_op_r <= OP_NONE;
      acc_r         <= {W{1'b0}};
      entry_r       <= {W{1'b0}};
      value_r       <= {W{1'b0}};
      n_r           <= N_ZERO;
      overflow_r    <= 1'b0;
    end else begin
      newkey_r <= newkey;
      if (mul_done_s) begin
        // Product lands in acc; shown both in RESULT and OP_WAIT.
        acc_r      <= mul_p_s[W-1:0];
        value_r    <= mul_p_s[W-1:0];
        overflow_r <= overflow_r | (|mul_p_s[2*W-1:W]);
        op_r       <= mul_next_op_r;
        state_r    <= mul_dest_r;
      end else if (srst_s) begin
        state_r    <= ST_ENTER_A;
        op_r       <= OP_NONE;
        acc_r      <= {W{1'b0}};
        entry_r    <= {W{1'b0}};
        value_r    <= {W{1'b0}};
        n_r        <= N_ZERO;
        overflow_r <= 1'b0;
      end else if (mul_start_s) begin
        state_r <= ST_MUL_RUN;
        if (keycode == KEY_SQUARE || keycode == KEY_EQUALS) begin
          mul_dest_r    <= ST_RESULT;
          mul_next_op_r <= OP_NONE;
        end else begin
          mul_dest_r    <= ST_OP_WAIT;
          mul_next_op_r <= key_op_s;
        end
      end else if (accept_s) begin
        if (keycode[4]) begin
          case (state_r)
            ST_ENTER_A, ST_ENTER_B: begin
              if (n_r < N_MAX) begin
                entry_r <= entry_shift_s;
                value_r <= entry_shift_s;
                n_r     <= n_r + N_ONE;
              end else begin
                n_r <= n_r;
              end
            end
            ST_OP_WAIT, ST_RESULT: begin
              entry_r <= entry_first_s;
              value_r <= entry_first_s;
              n_r     <= N_ONE;
              state_r <= (state_r == ST_OP_WAIT) ? ST_ENTER_B : ST_ENTER_A;
            end
            default: begin
              n_r <= n_r;
            end
          endcase
        end else if (key_op_s != OP_NONE) begin
          case (state_r)
            ST_ENTER_A, ST_RESULT: begin
              acc_r   <= value_r;
              op_r    <= key_op_s;
              state_r <= ST_OP_WAIT;
            end
            ST_ENTER_B: begin
              // Chaining: fold the pending add/sub into acc first.
              acc_r      <= alu_res_s;
              value_r    <= alu_res_s;
              overflow_r <= overflow_r | alu_ovf_s;
              op_r       <= key_op_s;
              state_r    <= ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
              op_r <= key_op_s;
            end
            default: begin
              op_r <= op_r;
            end
          endcase
        end else if (keycode == KEY_EQUALS) begin
          if (state_r == ST_ENTER_B) begin
            acc_r      <= alu_res_s;
            value_r    <= alu_res_s;
            overflow_r <= overflow_r | alu_ovf_s;
            op_r       <= OP_NONE;
            state_r    <= ST_RESULT;
          end else begin
            state_r <= state_r;
          end
        end else if (keycode == KEY_CE) begin
          entry_r <= {W{1'b0}};
          n_r     <= N_ZERO;
          if (state_r == ST_ENTER_A || state_r == ST_ENTER_B) begin
            value_r <= {W{1'b0}};
          end else begin
            value_r <= value_r;
          end
        end else begin
          state_r <= state_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
// tb_calc_core_param: directed vectors with hand-computed expected values
// for calc_core_param at DIGITS = 5.
module tb_calc_core_param;

  logic        clock;
  logic        reset;
  logic        newkey;
  logic [4:0]  keycode;
  logic [19:0] value;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] K_SQ  = 5'b00001;
  localparam logic [4:0] K_CE  = 5'b00010;
  localparam logic [4:0] K_EQ  = 5'b00100;
  localparam logic [4:0] K_ADD = 5'b01001;
  localparam logic [4:0] K_MUL = 5'b01010;
  localparam logic [4:0] K_SUB = 5'b01011;
  localparam logic [4:0] K_AC  = 5'b01100;

  calc_core_param #(.DIGITS(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .newkey   (newkey),
    .keycode  (keycode),
    .value    (value),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clock);
    keycode = k;
    newkey  = 1'b1;
    @(negedge clock);
    newkey  = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    press({1'b1, d});
  endtask

  task automatic hold(input logic [4:0] k, input int cycles);
    @(negedge clock);
    keycode = k;
    newkey  = 1'b1;
    repeat (cycles) @(negedge clock);
    newkey  = 1'b0;
  endtask

  // Press a key that starts the multiplier; measure busy, check the displayed
  // value mid-run, and hold a digit across the busy fall (must not be taken).
  task automatic press_mul(input logic [4:0] k, input logic [19:0] pre_exp);
    int cnt;
    @(negedge clock);
    keycode = k;
    newkey  = 1'b1;
    @(negedge clock);
    newkey  = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == 3) chk("pre_mul_value", 32'(value), 32'(pre_exp));
      if (cnt == 5) begin
        keycode = 5'h17;
        newkey  = 1'b1;
      end
      @(negedge clock);
    end
    chk("busy_len", 32'(cnt), 32'd20);
    @(negedge clock);
    @(negedge clock);
    newkey = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    newkey  = 1'b0;
    keycode = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // 25 + 6B = 90
    digit(4'h2); digit(4'h5);
    chk("add_a", 32'(value), 32'h25);
    press(K_ADD);
    chk("add_op", 32'(value), 32'h25);
    digit(4'h6);
    chk("add_b1", 32'(value), 32'h6);
    digit(4'hB);
    chk("add_b2", 32'(value), 32'h6B);
    press(K_EQ);
    chk("add_res", 32'(value), 32'h90);
    chk("add_ovf", 32'(overflow), 32'h0);

    // 3B * 1A = 5FE, digit during busy dropped
    digit(4'h3); digit(4'hB);
    press(K_MUL);
    chk("mul_op", 32'(value), 32'h3B);
    digit(4'h1); digit(4'hA);
    press_mul(K_EQ, 20'h1A);
    chk("mul_res", 32'(value), 32'h5FE);
    chk("mul_ovf", 32'(overflow), 32'h0);

    // square 5FE -> 23E804 truncated
    press_mul(K_SQ, 20'h5FE);
    chk("sq_res", 32'(value), 32'h3E804);
    chk("sq_ovf", 32'(overflow), 32'h1);
    press(K_AC);
    chk("ac_value", 32'(value), 32'h0);
    chk("ac_ovf", 32'(overflow), 32'h0);

    // 15 - 20 wraps with borrow
    digit(4'h1); digit(4'h5);
    press(K_SUB);
    digit(4'h2); digit(4'h0);
    press(K_EQ);
    chk("sub_res", 32'(value), 32'hFFFF5);
    chk("sub_ovf", 32'(overflow), 32'h1);
    press(K_AC);

    // CE replaces second operand
    digit(4'hC); digit(4'h5);
    press(K_ADD);
    digit(4'h7); digit(4'h2);
    press(K_CE);
    chk("ce_value", 32'(value), 32'h0);
    digit(4'h9); digit(4'hD);
    press(K_EQ);
    chk("ce_res", 32'(value), 32'h162);
    chk("ce_ovf", 32'(overflow), 32'h0);
    press(K_AC);

    // chaining: DA + 81 then * 4C
    digit(4'hD); digit(4'hA);
    press(K_ADD);
    digit(4'h8); digit(4'h1);
    press(K_MUL);
    chk("chain_mid", 32'(value), 32'h15B);
    digit(4'h4); digit(4'hC);
    press_mul(K_EQ, 20'h4C);
    chk("chain_res", 32'(value), 32'h6704);
    chk("chain_ovf", 32'(overflow), 32'h0);
    press(K_AC);

    // six digits, the sixth is ignored
    for (int i = 1; i <= 6; i++) digit(4'(i));
    chk("digits_max", 32'(value), 32'h12345);
    press(K_AC);

    // key held five cycles enters once
    hold(5'h17, 5);
    @(negedge clock);
    chk("hold_once", 32'(value), 32'h7);

    // reset mid-multiply
    press(K_SQ);
    repeat (4) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_value", 32'(value), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (25) @(negedge clock);
    chk("abort_stays_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_core_param.md
# calc_core_param

Parametrised next-generation calculator core: accepts key events from the keypad scanner and presents a hex value to the display driver. Widths are set by a digit-count parameter. Over the fixed 5-digit core it adds subtraction, operator chaining, a sticky overflow flag and a multi-cycle shift-add multiplier with a `busy` output.

## Interface
- `DIGITS`, default 5: number of hex digits held and displayed. W = 4·DIGITS.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `newkey`  in  1  key-valid level from the keypad; a key is accepted on its rising edge only.
- `keycode`  in  5  key code, stable while `newkey` is high.
- `value`  out  W  number shown on the display.
- `overflow`  out  1  sticky flag; the last result did not fit in W bits.
- `busy`  out  1  multiplier running; keys are ignored.

## Operation
- Key codes:
  - `1_dddd`: hex digit d.
  - `00001`: square.
  - `00010`: CE.
  - `00100`: equals.
  - `01001`: add.
  - `01010`: multiply.
  - `01011`: subtract.
  - `01100`: AC.
  - All other codes: no operation.
- Key accept: `newkey` is registered. A key is accepted when `newkey`=1 and its registered copy is 0 and `busy`=0. A key held high for any number of cycles is accepted once.
- Registers: `acc` (W bits), `entry` (W bits), `op` (none/add/sub/mul), digit count `n` (0..DIGITS).
- States: ENTER_A, OP_WAIT, ENTER_B, MUL_RUN, RESULT. Reset and AC go to ENTER_A with all registers 0.
- Digit key:
  - `entry` ← (`entry`<<4)|d and `n`++. In OP_WAIT and RESULT, `entry` restarts at d with `n`=1.
  - OP_WAIT goes to ENTER_B. RESULT goes to ENTER_A.
  - When `n`=DIGITS, the digit is ignored.
- Operator key (add/sub/mul):
  - From ENTER_A or RESULT: `acc` ← displayed value, `op` latched, go to OP_WAIT.
  - From ENTER_B: the pending op is evaluated first (chaining). The result goes to `acc`, then the new `op` is latched and the state goes to OP_WAIT.
  - In OP_WAIT: only `op` is replaced.
- Equals:
  - From ENTER_B: evaluates `acc` op `entry`, shows the result, goes to RESULT.
  - In any other state: no operation.
- Square: evaluates value×value and goes to RESULT. Any pending op is discarded.
- CE: `entry` ← 0 and `n` ← 0; `acc` and `op` are kept. In RESULT, CE acts as AC.
- Arithmetic is unsigned, modulo 2^W.
  - add: `overflow` set on carry-out.
  - sub: `overflow` set on borrow; the wrapped result is shown.
  - mul and square: the 2W-bit product is truncated to its low W bits; `overflow` set when the high W bits are nonzero.
- `overflow` is cleared only by reset and AC; otherwise it is sticky.
- `value` shows:
  - `entry` in ENTER_A/ENTER_B;
  - `acc` in OP_WAIT;
  - the result in RESULT;
  - the pre-multiply value while in MUL_RUN.

## Timing
- Reset values: `value`=0, `overflow`=0, `busy`=0.
- Add/sub/digit/CE/AC: `value` and `overflow` update at the clock edge after the accept cycle (1-cycle latency).
- Multiply/square:
  - `busy` rises at the edge after accept and stays high for exactly W cycles.
  - `value`, `overflow` and the state update on the same edge where `busy` falls.
- Keys accepted while `busy`=1 are dropped, not queued. A `newkey` that is already high when `busy` falls is not accepted; it needs a fresh rising edge.
- Reset asserted mid-multiply: the multiplier aborts at once and all outputs go to their reset values asynchronously.

## Structure
- Package `calc_pkg`: key-code localparams, the state enum, and the op enum.
- Sub-module `calc_seq_mul #(W)`:
  - Radix-2 shift-add multiplier with ports `start`, `a`, `b`, `busy`, `done`, `p[2W-1:0]`.
  - Same clock and reset as the core.
  - Used for both multiply and square.

## Test plan
All scenarios use `DIGITS`=5.
- Digits 2,5, add, 6,B, equals: `value` is 25, 25, 6, 6B, then 90; `overflow`=0.
- Digits 3,B, mul, 1,A, equals: `busy` is high for 20 cycles, then `value`=5FE. A digit pressed during `busy` is ignored.
- Square after 5FE: `value`=3E804, `overflow`=1. After AC: `value`=0, `overflow`=0.
- Digits 1,5, sub, 2,0, equals: `value`=FFFF5, `overflow`=1. Separately, digits C,5, add, 7,2, CE, 9,D, equals: `value`=162.
- Chaining: D,A, add, 8,1, mul shows 15B; then 4,C, equals gives 6704.
- Edge cases:
  - Digits 1..6 give `value`=12345.
  - `newkey` held for 5 cycles enters one digit.
  - Reset pulsed mid-multiply gives `value`=0 and `busy`=0 immediately.
